// File: rtl/touch_svc_pkg.sv
// -----------------------------------------------------------------------------
// touch_svc_pkg
// Shared types and constants for touch_irq_servicer and its down-counter.
//   state_t      : FSM state encoding (HOLDOFF exists only when the
//                  TOUCH_IRQ_SERVICER_HOLDOFF_EN macro is defined)
//   *_OFS        : word offsets in the touch PIO register map
//   MASK_ENABLE  : value written to the irq mask register after reset
//   EDGE_CLEAR   : value written to the edge-capture register to clear it
//   bits_for()   : number of bits needed to hold a non-negative value
// -----------------------------------------------------------------------------
package touch_svc_pkg;

  typedef enum logic [3:0] {
    INIT_MASK,
    IDLE,
    RD_EDGE,
    WAIT_EDGE,
    CLR_EDGE,
    RD_DATA,
    WAIT_DATA,
    REPORT
`ifdef TOUCH_IRQ_SERVICER_HOLDOFF_EN
    , HOLDOFF
`endif
  } state_t;

  localparam logic [1:0]  DATA_OFS    = 2'd0;
  localparam logic [1:0]  MASK_OFS    = 2'd2;
  localparam logic [1:0]  EDGE_OFS    = 2'd3;
  localparam logic [31:0] MASK_ENABLE = 32'h0000_0001;
  localparam logic [31:0] EDGE_CLEAR  = 32'h0000_0000;

  // Width of a counter able to hold 'value'; never less than one bit.
  function automatic int bits_for(input int value);
    int w;
    w = 1;
    while ((1 << w) <= value) w++;
    return w;
  endfunction

endpackage

// File: rtl/touch_svc_latency_cnt.sv
// -----------------------------------------------------------------------------
// touch_svc_latency_cnt
// Loadable down-counter that stops at zero. Used to time the slave read
// latency and, in holdoff builds, the debounce holdoff interval.
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   load       in  load load_value (has priority over dec)
//   load_value in  W-bit value to load
//   dec        in  decrement by one when non-zero
//   count      out current count
//   zero       out count equals zero
// -----------------------------------------------------------------------------
module touch_svc_latency_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/touch_irq_servicer.sv
// -----------------------------------------------------------------------------
// touch_irq_servicer
// Avalon-MM master that services the touch-controller interrupt PIO without
// processor help: after reset it enables the PIO irq mask; on each irq it
// reads edge-capture, clears it, samples the pin level and emits a one-cycle
// touch event with a saturating event count.
//
// Optional build macro: TOUCH_IRQ_SERVICER_HOLDOFF_EN adds parameter
// HOLDOFF_CYCLES and a HOLDOFF state after REPORT during which irq is ignored
// (debounce). Without the macro REPORT returns straight to IDLE.
//
// Parameters:
//   READ_LATENCY  slave address-to-readdata latency in cycles (1..4)
//   COUNT_W       width of the saturating event counter
//   HOLDOFF_CYCLES (holdoff builds only) debounce interval in cycles
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   enable                      allow new service sequences to start
//   irq                         level interrupt from the touch PIO
//   avm_address/chipselect/
//   write_n/writedata/readdata  Avalon-MM master interface to the PIO
//   event_valid                 one-cycle pulse per serviced touch edge
//   event_level                 pin level read during the service
//   event_count                 serviced-event count, saturating
//   busy                        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module touch_irq_servicer
  import touch_svc_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int COUNT_W      = 16
`ifdef TOUCH_IRQ_SERVICER_HOLDOFF_EN
  , parameter int HOLDOFF_CYCLES = 1000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               irq,
  output logic [1:0]         avm_address,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [31:0]        avm_writedata,
  input  logic [31:0]        avm_readdata,
  output logic               event_valid,
  output logic               event_level,
  output logic [COUNT_W-1:0] event_count,
  output logic               busy
);

`ifdef TOUCH_IRQ_SERVICER_HOLDOFF_EN
  localparam int CNT_MAX = (HOLDOFF_CYCLES > READ_LATENCY) ? HOLDOFF_CYCLES
                                                           : READ_LATENCY;
`else
  localparam int CNT_MAX = READ_LATENCY;
`endif
  localparam int CNT_W = bits_for(CNT_MAX);

  state_t             state;
  logic               edge_seen;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_value;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               cnt_last;

  // Only bit 0 of each PIO register is meaningful to this block.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:1];

  touch_svc_latency_cnt #(
    .W (CNT_W)
  ) u_latency_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // cnt == 1 marks the cycle in which the slave's readdata is valid; the
  // following cycle (cnt == 0) acts on the bit registered from it.
  assign cnt_last = (cnt == CNT_W'(1));

  // Counter control: loaded during each read strobe, run down in the wait.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    cnt_load       = 1'b0;
    cnt_load_value = CNT_W'(READ_LATENCY);
    cnt_dec        = 1'b0;
    case (state)
      RD_EDGE, RD_DATA:     cnt_load = 1'b1;
      WAIT_EDGE, WAIT_DATA: cnt_dec  = 1'b1;
`ifdef TOUCH_IRQ_SERVICER_HOLDOFF_EN
      REPORT: begin
        cnt_load       = 1'b1;
        cnt_load_value = CNT_W'(HOLDOFF_CYCLES);
      end
      HOLDOFF:              cnt_dec  = 1'b1;
`endif
      default: ;
    endcase
  end

  // Single FSM with registered outputs. Bus strobes are set on the edge that
  // enters RD_EDGE / CLR_EDGE / RD_DATA so they coincide with that state.
  // The mask write is launched on the edge leaving INIT_MASK (the reset
  // values keep the bus idle during reset), so it occupies the first IDLE
  // cycle; no irq can be pending before that write lands anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= INIT_MASK;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      event_valid    <= 1'b0;
      event_level    <= 1'b0;
      event_count    <= '0;
      busy           <= 1'b1;
      edge_seen      <= 1'b0;
    end else begin
      // Strobes and the event pulse are one cycle wide unless re-asserted.
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      event_valid    <= 1'b0;

      case (state)
        INIT_MASK: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= MASK_OFS;
          avm_writedata  <= MASK_ENABLE;
          state          <= IDLE;
          busy           <= 1'b0;
        end

        IDLE: begin
          if (irq && enable) begin
            avm_chipselect <= 1'b1;
            avm_address    <= EDGE_OFS;
            state          <= RD_EDGE;
            busy           <= 1'b1;
          end
        end

        RD_EDGE: state <= WAIT_EDGE;

        WAIT_EDGE: begin
          if (cnt_last) edge_seen <= avm_readdata[0];
          if (cnt_zero) begin
            if (edge_seen) begin
              avm_chipselect <= 1'b1;
              avm_write_n    <= 1'b0;
              avm_address    <= EDGE_OFS;
              avm_writedata  <= EDGE_CLEAR;
              state          <= CLR_EDGE;
            end else begin
              // Spurious irq: nothing captured, nothing to clear or report.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        CLR_EDGE: begin
          avm_chipselect <= 1'b1;
          avm_address    <= DATA_OFS;
          state          <= RD_DATA;
        end

        RD_DATA: state <= WAIT_DATA;

        WAIT_DATA: begin
          if (cnt_last) event_level <= avm_readdata[0];
          if (cnt_zero) begin
            event_valid <= 1'b1;
            if (event_count != '1) event_count <= event_count + COUNT_W'(1);
            state <= REPORT;
          end
        end

`ifdef TOUCH_IRQ_SERVICER_HOLDOFF_EN
        REPORT: state <= HOLDOFF;

        HOLDOFF: begin
          if (cnt_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`else
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`endif

        default: begin
          state <= INIT_MASK;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
